regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, 32, data width in bits.
REQ-002 Parameter NREGS, 32, register count; power of two, >=2; AW = clog2(NREGS).
REQ-003 Parameter NRD, 2, number of combinational read ports.
REQ-004 Parameter NWR, 1, number of core write ports.
REQ-005 One clock; reset is asynchronous and active-low; ports clk and rstn_i.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rstn_i  in  1  asynchronous active-low reset.
REQ-008 halt_i  in  1  core halted; debug port owns the file.
REQ-009 flush_i  in  1  clear all scoreboard busy bits.
REQ-010 rs_addr_i  in  NRD*AW  read addresses.
REQ-011 rs_data_o  out  NRD*XLEN  read data.
REQ-012 rs_busy_o  out  NRD  operand pending a writeback.
REQ-013 iss_valid_i / iss_rd_i / iss_ack_o  in 1 / in AW / out 1  destination-reservation handshake.
REQ-014 wr_valid_i / wr_addr_i / wr_data_i  in NWR / in NWR*AW / in NWR*XLEN  core writeback ports.
REQ-015 dbg_req_i / dbg_we_i / dbg_addr_i / dbg_wdata_i  in 1 / 1 / AW / XLEN  debug request.
REQ-016 dbg_ack_o / dbg_rdata_o  out 1 / XLEN  debug response.

Function
REQ-017 Register 0 SHALL read zero, ignore all writes, and never report busy.
REQ-018 Reads SHALL be combinational, with write-through bypass: a same-cycle accepted write to the read address is returned.
REQ-019 Multiple writes to one address in one cycle: lowest port index wins, for both storage and bypass.
REQ-020 Writes SHALL commit at the rising edge; wr_valid_i is ignored while halt_i=1.
REQ-021 iss_ack_o = iss_valid_i & !busy[iss_rd_i] & !halt_i & !flush_i, combinational (WAW stall).
REQ-022 An accepted issue SHALL set busy[iss_rd_i] at the edge; iss_rd_i=0 is acked but sets nothing.
REQ-023 A committed write SHALL clear busy[addr]; a same-cycle issue to that address wins and leaves it set.
REQ-024 rs_busy_o[i] = busy[addr_i] & no same-cycle accepted write to addr_i.
REQ-025 flush_i SHALL clear every busy bit at the next edge; register contents are unaffected.
REQ-026 Debug FSM states IDLE, ACCESS, RESP:
- IDLE->ACCESS on dbg_req_i & halt_i; latch addr, we, wdata.
- Requests without halt_i are ignored.
REQ-027 ACCESS->RESP unconditionally; perform the write (clearing that register's busy bit), or capture the read into dbg_rdata_o.
REQ-028 RESP: dbg_ack_o=1 for exactly one cycle, then IDLE; dbg_rdata_o holds until the next read capture.
REQ-029 halt_i deasserting in ACCESS or RESP SHALL NOT abort the transaction.
REQ-030 Debug write data is visible on rs_data_o from the edge leaving ACCESS.
REQ-031 Latency: request sampled at edge N; dbg_ack_o high between edges N+2 and N+3.

Reset
REQ-032 On rstn_i=0, asynchronously:
- all registers 0, all busy bits 0, FSM IDLE;
- dbg_ack_o=0, dbg_rdata_o=0.
REQ-033 Reset mid-debug-transaction SHALL drop it with no ack and no write.

Structure
REQ-034 The debug state enum and default XLEN/NREGS SHALL live in the shared core package.
REQ-035 The busy-bit scoreboard SHALL be the sub-module regfile_scoreboard (issue, clear, flush, lookup).

Verification
REQ-036 Write 0xDEADBEEF to x5 while reading x5 on port 0 -> same-cycle rs_data_o=0xDEADBEEF; next cycle also 0xDEADBEEF.
REQ-037 Issue rd=7, then issue rd=7 again -> second iss_ack_o=0 until the write to x7 commits; rs_busy_o=1 on reads of x7 meanwhile.
REQ-038 NWR=2, both ports write x3 (0x1, 0x2) -> x3=0x1.
REQ-039 halt_i=1; debug write x9=0x1234, then debug read x9 -> each ack 2 cycles after req; dbg_rdata_o=0x1234.
REQ-040 Debug write x0=0xFFFF -> read returns 0.
REQ-041 Busy x4, x6, then flush_i -> both clear next cycle; issue during flush not acked.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared definitions for the multi-port register file
//
// Purpose: default data width and register count, and the debug access
// state encoding used by regfile_mp.
// Ports: none (package).

package regfile_mp_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_ACCESS = 2'd1,
    DBG_RESP   = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard for pending register writebacks
//
// Purpose: one busy bit per register. An issue sets a bit, a committed write
// clears it (issue wins on the same register), flush clears everything.
// Bit 0 is never set.
// Ports:
//   clk, rstn_i          clock, asynchronous active-low reset
//   iss_set, iss_addr    accepted destination reservation
//   clr_mask             one bit per register to clear this cycle
//   flush                clear all busy bits at the next edge
//   lk_addr / lk_busy    NRD lookup ports (raw busy state)
//   iss_busy             busy state of iss_addr (for the WAW stall)

module regfile_scoreboard #(
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              iss_set,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NREGS-1:0]  clr_mask,
  input  logic              flush,
  input  logic [NRD*AW-1:0] lk_addr,
  output logic [NRD-1:0]    lk_busy,
  output logic              iss_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~clr_mask;
      // Applied after the clear so a same-cycle reservation survives.
      if (iss_set) busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    lk_busy = '0;
    for (int i = 0; i < NRD; i++) lk_busy[i] = busy_q[lk_addr[i*AW +: AW]];
  end

  assign iss_busy = busy_q[iss_addr];

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with scoreboard and debug port
//
// Purpose: NRD combinational read ports with write-through bypass, NWR core
// write ports (lowest index wins), destination reservation with WAW stall,
// and a halt-gated debug read/write port.
// Ports:
//   clk, rstn_i                         clock, asynchronous active-low reset
//   halt_i, flush_i                     core halted / clear all busy bits
//   rs_addr_i, rs_data_o, rs_busy_o     read ports
//   iss_valid_i, iss_rd_i, iss_ack_o    destination reservation handshake
//   wr_valid_i, wr_addr_i, wr_data_i    core writeback ports
//   dbg_req_i, dbg_we_i, dbg_addr_i,
//   dbg_wdata_i, dbg_ack_o, dbg_rdata_o debug request / response

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN  = DEF_XLEN,
  parameter  int NREGS = DEF_NREGS,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rstn_i,
  input  logic                halt_i,
  input  logic                flush_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic                iss_ack_o,
  input  logic [NWR-1:0]      wr_valid_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [AW-1:0]       dbg_addr_i,
  input  logic [XLEN-1:0]     dbg_wdata_i,
  output logic                dbg_ack_o,
  output logic [XLEN-1:0]     dbg_rdata_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NWR-1:0]   we;
  logic [NRD-1:0]   rd_hit;
  logic [NRD-1:0]   lk_busy;
  logic             iss_busy;
  logic [NREGS-1:0] clr_mask;

  dbg_state_t       state_q, state_d;
  logic [AW-1:0]    dbg_addr_q;
  logic             dbg_we_q;
  logic [XLEN-1:0]  dbg_wdata_q;
  logic             dbg_wr;

  // Core writes are dropped while halted; writes to x0 never count as
  // accepted, so they neither bypass nor clear anything.
  always_comb begin
    we = '0;
    for (int p = 0; p < NWR; p++)
      we[p] = wr_valid_i[p] & ~halt_i & (wr_addr_i[p*AW +: AW] != '0);
  end

  // Scan from the highest port down so the lowest matching port is applied last.
  always_comb begin
    rs_data_o = '0;
    rd_hit    = '0;
    for (int i = 0; i < NRD; i++) begin
      rs_data_o[i*XLEN +: XLEN] = regs[rs_addr_i[i*AW +: AW]];
      for (int p = NWR - 1; p >= 0; p--) begin
        if (we[p] && (wr_addr_i[p*AW +: AW] == rs_addr_i[i*AW +: AW])) begin
          rs_data_o[i*XLEN +: XLEN] = wr_data_i[p*XLEN +: XLEN];
          rd_hit[i] = 1'b1;
        end
      end
    end
  end

  assign rs_busy_o = lk_busy & ~rd_hit;
  assign iss_ack_o = iss_valid_i & ~iss_busy & ~halt_i & ~flush_i;
  assign dbg_wr    = (state_q == DBG_ACCESS) && dbg_we_q && (dbg_addr_q != '0);

  always_comb begin
    clr_mask = '0;
    for (int p = 0; p < NWR; p++)
      if (we[p]) clr_mask[wr_addr_i[p*AW +: AW]] = 1'b1;
    if (dbg_wr) clr_mask[dbg_addr_q] = 1'b1;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .iss_set  (iss_ack_o),
    .iss_addr (iss_rd_i),
    .clr_mask (clr_mask),
    .flush    (flush_i),
    .lk_addr  (rs_addr_i),
    .lk_busy  (lk_busy),
    .iss_busy (iss_busy)
  );

  // Storage. The debug write comes last so it wins over a core write that
  // slips in after halt drops mid-transaction.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = NWR - 1; p >= 0; p--)
        if (we[p]) regs[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
      if (dbg_wr) regs[dbg_addr_q] <= dbg_wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DBG_IDLE:   if (dbg_req_i && halt_i) state_d = DBG_ACCESS;
      DBG_ACCESS: state_d = DBG_RESP;
      DBG_RESP:   state_d = DBG_IDLE;
      default:    state_d = DBG_IDLE;
    endcase
  end

  // dbg_ack_o is registered off RESP, so it is high in the cycle after RESP.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= DBG_IDLE;
      dbg_addr_q  <= '0;
      dbg_we_q    <= 1'b0;
      dbg_wdata_q <= '0;
      dbg_rdata_o <= '0;
      dbg_ack_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dbg_ack_o <= (state_q == DBG_RESP);
      if (state_q == DBG_IDLE && dbg_req_i && halt_i) begin
        dbg_addr_q  <= dbg_addr_i;
        dbg_we_q    <= dbg_we_i;
        dbg_wdata_q <= dbg_wdata_i;
      end
      if (state_q == DBG_ACCESS && !dbg_we_q) dbg_rdata_o <= regs[dbg_addr_q];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp

module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rstn_i;
  logic                halt_i, flush_i;
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_busy_o;
  logic                iss_valid_i;
  logic [AW-1:0]       iss_rd_i;
  logic                iss_ack_o;
  logic [NWR-1:0]      wr_valid_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                dbg_req_i, dbg_we_i;
  logic [AW-1:0]       dbg_addr_i;
  logic [XLEN-1:0]     dbg_wdata_i;
  logic                dbg_ack_o;
  logic [XLEN-1:0]     dbg_rdata_o;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR)) dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .halt_i      (halt_i),
    .flush_i     (flush_i),
    .rs_addr_i   (rs_addr_i),
    .rs_data_o   (rs_data_o),
    .rs_busy_o   (rs_busy_o),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .iss_ack_o   (iss_ack_o),
    .wr_valid_i  (wr_valid_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .dbg_req_i   (dbg_req_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_rdata_o (dbg_rdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rs_addr_i[port*AW +: AW] = a;
    #1;
  endtask

  task automatic set_wr(input int port, input logic v, input logic [AW-1:0] a, input logic [31:0] d);
    wr_valid_i[port]             = v;
    wr_addr_i[port*AW +: AW]     = a;
    wr_data_i[port*XLEN +: XLEN] = d;
  endtask

  // Request presented before edge N; ack expected only between N+2 and N+3.
  task automatic dbg_txn(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic drop_halt);
    dbg_req_i = 1'b1; dbg_we_i = w; dbg_addr_i = a; dbg_wdata_i = d;
    tick();
    dbg_req_i = 1'b0;
    if (drop_halt) halt_i = 1'b0;
    #1 check({tag, "_ack_n0"}, {31'b0, dbg_ack_o}, 32'd0);
    tick(); check({tag, "_ack_n1"}, {31'b0, dbg_ack_o}, 32'd0);
    tick(); check({tag, "_ack_n2"}, {31'b0, dbg_ack_o}, 32'd1);
    tick(); check({tag, "_ack_n3"}, {31'b0, dbg_ack_o}, 32'd0);
  endtask

  initial begin
    rstn_i = 1'b0; halt_i = 0; flush_i = 0;
    rs_addr_i = '0; iss_valid_i = 0; iss_rd_i = '0;
    wr_valid_i = '0; wr_addr_i = '0; wr_data_i = '0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0;
    #12;
    set_rd(0, 5'd5);
    check("rst_rdata_x5", rs_data_o[31:0], 32'h0);
    check("rst_dbg_ack", {31'b0, dbg_ack_o}, 32'd0);
    check("rst_dbg_rdata", dbg_rdata_o, 32'h0);
    check("rst_busy", {30'b0, rs_busy_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;

    // Write-through bypass and commit
    set_wr(0, 1, 5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5);
    check("bypass_x5", rs_data_o[31:0], 32'hDEADBEEF);
    tick(); set_wr(0, 0, 5'd0, 32'h0); #1;
    check("commit_x5", rs_data_o[31:0], 32'hDEADBEEF);

    // Two ports to one address: port 0 wins
    set_wr(0, 1, 5'd3, 32'h1);
    set_wr(1, 1, 5'd3, 32'h2);
    set_rd(1, 5'd3);
    check("dual_bypass_x3", rs_data_o[63:32], 32'h1);
    tick(); set_wr(0, 0, 5'd0, 32'h0); set_wr(1, 0, 5'd0, 32'h0); #1;
    check("dual_commit_x3", rs_data_o[63:32], 32'h1);

    // x0 ignores core writes
    set_wr(0, 1, 5'd0, 32'h55);
    set_rd(0, 5'd0);
    check("x0_bypass", rs_data_o[31:0], 32'h0);
    tick(); set_wr(0, 0, 5'd0, 32'h0); #1;
    check("x0_commit", rs_data_o[31:0], 32'h0);

    // WAW stall on x7
    iss_valid_i = 1; iss_rd_i = 5'd7; #1;
    check("iss7_first_ack", {31'b0, iss_ack_o}, 32'd1);
    tick();
    check("iss7_second_ack", {31'b0, iss_ack_o}, 32'd0);
    set_rd(0, 5'd7);
    check("x7_busy", {31'b0, rs_busy_o[0]}, 32'd1);
    tick();
    check("iss7_still_stalled", {31'b0, iss_ack_o}, 32'd0);
    set_wr(0, 1, 5'd7, 32'h77); #1;
    check("x7_busy_bypassed", {31'b0, rs_busy_o[0]}, 32'd0);
    check("iss7_ack_during_wb", {31'b0, iss_ack_o}, 32'd0);
    tick(); set_wr(0, 0, 5'd0, 32'h0); #1;
    check("iss7_ack_after_wb", {31'b0, iss_ack_o}, 32'd1);
    check("x7_data", rs_data_o[31:0], 32'h77);
    check("x7_not_busy", {31'b0, rs_busy_o[0]}, 32'd0);
    iss_valid_i = 0;

    // rd=0 acked, never busy
    iss_valid_i = 1; iss_rd_i = 5'd0; #1;
    check("iss0_ack", {31'b0, iss_ack_o}, 32'd1);
    tick();
    set_rd(0, 5'd0);
    check("x0_never_busy", {31'b0, rs_busy_o[0]}, 32'd0);
    check("iss0_ack_again", {31'b0, iss_ack_o}, 32'd1);
    iss_valid_i = 0;

    // Flush clears x4, x6; issue during flush refused
    iss_valid_i = 1; iss_rd_i = 5'd4; tick();
    iss_rd_i = 5'd6; tick();
    iss_valid_i = 0;
    set_rd(0, 5'd4); set_rd(1, 5'd6);
    check("busy_x4_x6", {30'b0, rs_busy_o}, 32'd3);
    flush_i = 1; iss_valid_i = 1; iss_rd_i = 5'd8; #1;
    check("iss_during_flush", {31'b0, iss_ack_o}, 32'd0);
    tick(); flush_i = 0; iss_valid_i = 0; #1;
    check("flush_cleared", {30'b0, rs_busy_o}, 32'd0);
    set_rd(0, 5'd8);
    check("x8_not_set", {31'b0, rs_busy_o[0]}, 32'd0);
    set_rd(1, 5'd5);
    check("flush_keeps_data", rs_data_o[63:32], 32'hDEADBEEF);

    // Halted core writes are ignored
    halt_i = 1;
    set_wr(0, 1, 5'd12, 32'hABC);
    set_rd(0, 5'd12);
    check("halt_no_bypass", rs_data_o[31:0], 32'h0);
    iss_valid_i = 1; iss_rd_i = 5'd13; #1;
    check("halt_no_iss", {31'b0, iss_ack_o}, 32'd0);
    iss_valid_i = 0;
    tick(); set_wr(0, 0, 5'd0, 32'h0); #1;
    check("halt_no_commit", rs_data_o[31:0], 32'h0);

    // Requests without halt are ignored
    halt_i = 0;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 5'd14; dbg_wdata_i = 32'hBAD;
    tick(); dbg_req_i = 0;
    repeat (3) tick();
    check("nohalt_no_ack", {31'b0, dbg_ack_o}, 32'd0);
    set_rd(0, 5'd14);
    check("nohalt_no_write", rs_data_o[31:0], 32'h0);

    // Debug write x9; visible from the edge leaving ACCESS
    halt_i = 1;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h1234;
    set_rd(0, 5'd9);
    tick(); dbg_req_i = 0; #1;
    check("dbgw9_not_yet", rs_data_o[31:0], 32'h0);
    tick();
    check("dbgw9_visible", rs_data_o[31:0], 32'h1234);
    check("dbgw9_ack_n1", {31'b0, dbg_ack_o}, 32'd0);
    tick(); check("dbgw9_ack_n2", {31'b0, dbg_ack_o}, 32'd1);
    tick(); check("dbgw9_ack_n3", {31'b0, dbg_ack_o}, 32'd0);

    // Debug write x0 then read back zero
    dbg_txn("dbgw0", 1, 5'd0, 32'hFFFF, 0);
    dbg_txn("dbgr0", 0, 5'd0, 32'h0, 0);
    check("dbgr0_data", dbg_rdata_o, 32'h0);

    // Debug read x9; data holds afterwards
    dbg_txn("dbgr9", 0, 5'd9, 32'h0, 0);
    check("dbgr9_data", dbg_rdata_o, 32'h1234);
    tick();
    check("dbgr9_hold", dbg_rdata_o, 32'h1234);

    // Debug write clears busy; halt dropping mid-transaction does not abort
    halt_i = 0;
    iss_valid_i = 1; iss_rd_i = 5'd11; tick();
    iss_valid_i = 0; halt_i = 1;
    set_rd(0, 5'd11);
    check("x11_busy", {31'b0, rs_busy_o[0]}, 32'd1);
    dbg_txn("dbgw11", 1, 5'd11, 32'h99, 1);
    check("x11_busy_cleared", {31'b0, rs_busy_o[0]}, 32'd0);
    check("x11_data", rs_data_o[31:0], 32'h99);

    // Reset mid-transaction: no ack, no write, all state cleared
    halt_i = 1;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 5'd10; dbg_wdata_i = 32'h55;
    tick(); dbg_req_i = 0;
    #1 rstn_i = 0;
    #1 check("rst_mid_ack", {31'b0, dbg_ack_o}, 32'd0);
    check("rst_mid_rdata", dbg_rdata_o, 32'h0);
    set_rd(0, 5'd5);
    check("rst_mid_x5", rs_data_o[31:0], 32'h0);
    tick(); rstn_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_mid_no_ack", {31'b0, dbg_ack_o}, 32'd0);
    end
    set_rd(0, 5'd10);
    check("rst_mid_no_write", rs_data_o[31:0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
